period_serial_receiver: RTL

Receives one serial lane of pixel period data, as driven by one output pin of the fast-readout chip, and reconstructs the per-pixel period words. It is the receive end of the period readout link. It lives in the companion FPGA/test harness, with one instance per output lane (8 column lanes plus 8 row lanes). Reconstructed words are presented one pixel at a time on a valid/ready interface for downstream capture or compare logic.

---
 rtl/fastreadout_link_pkg.sv | 27 ++
 rtl/period_serial_receiver_if.sv | 29 ++
 rtl/period_word_unloader.sv | 77 +++++++
 rtl/period_serial_receiver.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/fastreadout_link_pkg.sv
// Shared definitions for the fast-readout period link: word size, lane
// geometry, line levels that frame a transfer, and the receiver state set.
// The transmitter side imports the same package so the frame format has a
// single definition.
package fastreadout_link_pkg;

  // One pixel period word and the number of words carried per frame.
  localparam int LINK_COUNTER_BITS    = 16;
  localparam int LINK_PIXELS_PER_LANE = 8;

  // Number of column lanes (and of row lanes) leaving the chip.
  localparam int LINK_NUM_LANES       = 8;

  // Line levels: idle low, start high, stop low.
  localparam logic LINK_IDLE_LEVEL = 1'b0;
  localparam logic LINK_START_BIT  = 1'b1;
  localparam logic LINK_STOP_BIT   = 1'b0;

  // Receiver framing states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    STOP   = 2'd2,
    RESYNC = 2'd3
  } rx_state_e;

endpackage

// File: rtl/period_serial_receiver_if.sv
// Valid/ready word channel carrying reconstructed pixel periods out of the
// lane receiver. The master drives words; the slave applies backpressure.
interface period_serial_receiver_if
  import fastreadout_link_pkg::*;
#(
  parameter int COUNTER_BITS = LINK_COUNTER_BITS,
  parameter int IDX_BITS     = $clog2(LINK_PIXELS_PER_LANE)
) ();

  logic                    pixel_valid;
  logic                    pixel_ready;
  logic [IDX_BITS-1:0]     pixel_index;
  logic [COUNTER_BITS-1:0] pixel_period;

  modport master (
    output pixel_valid,
    output pixel_index,
    output pixel_period,
    input  pixel_ready
  );

  modport slave (
    input  pixel_valid,
    input  pixel_index,
    input  pixel_period,
    output pixel_ready
  );

endinterface

// File: rtl/period_word_unloader.sv
// Single-frame buffer for one lane. A received frame is captured whole, then
// presented one pixel word at a time on the valid/ready channel, pixel 0
// first. The buffer reports itself full until the last word is accepted, so
// a frame completing in that same cycle is still refused.
module period_word_unloader
  import fastreadout_link_pkg::*;
#(
  parameter int  COUNTER_BITS    = LINK_COUNTER_BITS,
  parameter int  PIXELS_PER_LANE = LINK_PIXELS_PER_LANE,
  localparam int FRAME_BITS      = COUNTER_BITS * PIXELS_PER_LANE,
  localparam int IDX_BITS        = $clog2(PIXELS_PER_LANE)
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  i_load,
  input  logic [FRAME_BITS-1:0] i_frame,
  output logic                  o_full,
  output logic                  o_frame_done,
  period_serial_receiver_if.master pix
);

  localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(PIXELS_PER_LANE - 1);

  logic [COUNTER_BITS-1:0] r_words [PIXELS_PER_LANE];
  logic                    r_full;
  logic [IDX_BITS-1:0]     r_index;

  logic w_take;
  logic w_hs;
  logic w_last;

  // A load is only honoured into an empty buffer; a full buffer is never
  // overwritten even if a load request slips through.
  assign w_take = i_load & ~r_full;
  assign w_hs   = r_full & pix.pixel_ready;
  assign w_last = (r_index == LAST_IDX);

  // Capture the whole frame, split into pixel words, when the buffer is free.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < PIXELS_PER_LANE; i++) begin
        r_words[i] <= '0;
      end
    end else if (w_take) begin
      for (int i = 0; i < PIXELS_PER_LANE; i++) begin
        r_words[i] <= i_frame[i*COUNTER_BITS +: COUNTER_BITS];
      end
    end
  end

  // Track buffer occupancy and step the output index on every handshake;
  // the last handshake empties the buffer and rewinds the index.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_full  <= 1'b0;
      r_index <= '0;
    end else if (w_take) begin
      r_full  <= 1'b1;
      r_index <= '0;
    end else if (w_hs) begin
      if (w_last) begin
        r_full  <= 1'b0;
        r_index <= '0;
      end else begin
        r_index <= r_index + 1'b1;
      end
    end
  end

  assign pix.pixel_valid  = r_full;
  assign pix.pixel_index  = r_index;
  assign pix.pixel_period = r_words[r_index];

  assign o_full       = r_full;
  assign o_frame_done = w_hs & w_last;

endmodule

// File: rtl/period_serial_receiver.sv
// Receive end of one period readout lane. Frames a serial stream
// (start bit, FRAME_BITS payload bits MSB-first, stop bit) into a shift
// register and hands good frames to the word unloader. Reception never waits
// on the output side; a good frame that finds the buffer busy is dropped and
// flagged as an overrun.
module period_serial_receiver
  import fastreadout_link_pkg::*;
#(
  parameter int  COUNTER_BITS    = LINK_COUNTER_BITS,
  parameter int  PIXELS_PER_LANE = LINK_PIXELS_PER_LANE,
  localparam int FRAME_BITS      = COUNTER_BITS * PIXELS_PER_LANE,
  localparam int IDX_BITS        = $clog2(PIXELS_PER_LANE)
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       data_in,
  period_serial_receiver_if.master pix,
  output logic       frame_done,
  output logic       frame_error,
  output logic       overrun,
  output logic [7:0] frame_count
);

  localparam int              CNT_W    = $clog2(FRAME_BITS);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_BITS - 1);

  rx_state_e             r_state;
  rx_state_e             w_state_nxt;
  logic [CNT_W-1:0]      r_bit_cnt;
  logic [FRAME_BITS-1:0] r_shift;

  logic       r_frame_error;
  logic       r_overrun;
  logic [7:0] r_frame_count;

  logic w_buf_full;
  logic w_load;
  logic w_drop;
  logic w_bad_stop;

  // Receiver state register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Framing decisions. The stop-bit cycle decides between load, drop and
  // error; the buffer's registered full flag is used, so a drain finishing
  // in the same cycle does not make room for this frame. After a bad stop
  // the line must return low before a new start bit is honoured.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_drop      = 1'b0;
    w_bad_stop  = 1'b0;
    case (r_state)
      IDLE: begin
        if (data_in == LINK_START_BIT) begin
          w_state_nxt = DATA;
        end
      end
      DATA: begin
        if (r_bit_cnt == LAST_BIT) begin
          w_state_nxt = STOP;
        end
      end
      STOP: begin
        if (data_in == LINK_STOP_BIT) begin
          w_state_nxt = IDLE;
          if (w_buf_full) begin
            w_drop = 1'b1;
          end else begin
            w_load = 1'b1;
          end
        end else begin
          w_bad_stop  = 1'b1;
          w_state_nxt = RESYNC;
        end
      end
      RESYNC: begin
        if (data_in == LINK_IDLE_LEVEL) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Payload shifter and bit counter; the first payload bit ends up in the MSB.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_bit_cnt <= '0;
      r_shift   <= '0;
    end else if (r_state == IDLE) begin
      r_bit_cnt <= '0;
    end else if (r_state == DATA) begin
      r_shift   <= {r_shift[FRAME_BITS-2:0], data_in};
      r_bit_cnt <= r_bit_cnt + 1'b1;
    end
  end

  // Status pulses follow the stop-bit cycle by one clock; good frames that
  // reach the buffer are counted, wrapping at 8 bits.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_frame_error <= 1'b0;
      r_overrun     <= 1'b0;
      r_frame_count <= '0;
    end else begin
      r_frame_error <= w_bad_stop;
      r_overrun     <= w_drop;
      if (w_load) begin
        r_frame_count <= r_frame_count + 8'd1;
      end
    end
  end

  period_word_unloader #(
    .COUNTER_BITS    (COUNTER_BITS),
    .PIXELS_PER_LANE (PIXELS_PER_LANE)
  ) u_unloader (
    .CLK          (CLK),
    .RST_N        (RST_N),
    .i_load       (w_load),
    .i_frame      (r_shift),
    .o_full       (w_buf_full),
    .o_frame_done (frame_done),
    .pix          (pix)
  );

  assign frame_error = r_frame_error;
  assign overrun     = r_overrun;
  assign frame_count = r_frame_count;

endmodule
